// File: rtl/permutation_sequencer.sv
// permutation_sequencer: valid/ready wrapper that steps the ASCON round core through N rounds.
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

module permutation_sequencer
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  output logic       ready_o,
  input  type_state  state_i,
  input  logic [3:0] nb_rounds_i,
  output logic       perm_select_o,
  output logic [3:0] perm_round_o,
  output type_state  perm_state_o,
  input  type_state  perm_state_i,
  output logic       valid_o,
  input  logic       ready_i,
  output type_state  state_o,
  output logic       busy_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, CAPTURE = 2'd2, OUT = 2'd3;
  logic [1:0] st;
  logic [3:0] cnt, n, nc;
  type_state  in_reg, out_reg;
  assign nc = (nb_rounds_i == 4'd0 || nb_rounds_i > 4'd12) ? 4'd12 : nb_rounds_i;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      st      <= IDLE;
      cnt     <= '0;
      n       <= '0;
      in_reg  <= '0;
      out_reg <= '0;
    end else
      case (st)
        IDLE: if (start_i) begin
          in_reg <= state_i;
          n      <= nc;
          cnt    <= 4'd12 - nc;
          st     <= RUN;
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11) st <= CAPTURE;
        end
        CAPTURE: begin
          out_reg <= perm_state_i;
          st      <= OUT;
        end
        OUT: if (ready_i) st <= IDLE;
      endcase
  // the first RUN cycle loads in_reg into the core; later cycles feed back its output
  assign perm_select_o = (st == RUN) && (cnt != 4'd12 - n);
  assign perm_round_o  = (st == RUN) ? cnt : 4'd0;
  assign perm_state_o  = in_reg;
  assign state_o       = out_reg;
  assign ready_o       = st == IDLE;
  assign busy_o        = st != IDLE;
  assign valid_o       = st == OUT;
endmodule
